mips_instr_encoder: RTL and testbench

//  Inverse of the opcode/control decode path: accepts symbolic MIPS instructions (mnemonic + fields)

---
 rtl/mips_instr_encoder_pkg.sv | 58 +++++
 rtl/mips_instr_encoder_pack.sv | 62 ++++++
 rtl/mips_instr_encoder.sv | 130 +++++++++++++
 tb/tb_mips_instr_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_instr_encoder_pkg.sv
// Shared types and encoding constants for the MIPS instruction encoder.
// Opcode/funct values match the decoder's opcode_t so encode/decode round-trips.
package mips_instr_encoder_pkg;

    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_LW   = 4'd5,
        MN_SW   = 4'd6,
        MN_BEQ  = 4'd7,
        MN_ADDI = 4'd8,
        MN_J    = 4'd9
    } mnem_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ALIGN    = 3'd1,
        ERR_BAD_OP   = 3'd2,
        ERR_BR_RANGE = 3'd3,
        ERR_J_REGION = 3'd4,
        ERR_MEM_OVF  = 3'd5
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } encode_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encoder_pack.sv
// Combinational encoder: symbolic instruction + current pc -> 32-bit word,
// with fault detection for unencodable requests.
module mips_instr_pack
    import mips_instr_encoder_pkg::*;
(
    input  mnem_t       op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] target,
    input  logic [31:0] pc,
    output logic [31:0] word,
    output logic        fault,
    output err_t        err_code
);

    logic [31:0] pc_next;
    logic [31:0] br_diff;
    logic [31:0] br_off;
    logic        br_in_range;

    assign pc_next     = pc + 32'd4;
    assign br_diff     = target - pc_next;
    assign br_off      = $signed(br_diff) >>> 2;
    // Offset fits in 16 bits signed when the upper 17 bits are a pure sign extension.
    assign br_in_range = (br_off[31:15] == '0) || (br_off[31:15] == '1);

    // Select the encoding for the mnemonic and flag anything that cannot be encoded.
    always_comb begin
        word     = '0;
        err_code = ERR_NONE;
        case (op)
            MN_ADD:  word = r_type(rs, rt, rd, FN_ADD);
            MN_SUB:  word = r_type(rs, rt, rd, FN_SUB);
            MN_AND:  word = r_type(rs, rt, rd, FN_AND);
            MN_OR:   word = r_type(rs, rt, rd, FN_OR);
            MN_SLT:  word = r_type(rs, rt, rd, FN_SLT);
            MN_LW:   word = i_type(OP_LW, rs, rt, imm);
            MN_SW:   word = i_type(OP_SW, rs, rt, imm);
            MN_ADDI: word = i_type(OP_ADDI, rs, rt, imm);
            MN_BEQ: begin
                if (target[1:0] != 2'b00 || !br_in_range) begin
                    err_code = ERR_BR_RANGE;
                end else begin
                    word = i_type(OP_BEQ, rs, rt, br_off[15:0]);
                end
            end
            MN_J: begin
                if (target[1:0] != 2'b00 || target[31:28] != pc_next[31:28]) begin
                    err_code = ERR_J_REGION;
                end else begin
                    word = {OP_J, target[27:2]};
                end
            end
            default: err_code = ERR_BAD_OP;
        endcase
    end

    assign fault = (err_code != ERR_NONE);

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams symbolic MIPS instructions into IMEM: accepts one request at a time,
// encodes it at the current pc and writes it with a held write strobe.
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  mnem_t             in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [31:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output err_t              err_code,
    output logic [ADDR_W:0]   instr_count
);

    encode_state_t state;
    logic [31:0]   pc;
    logic          last_q;
    logic [31:0]   enc_word;
    logic          enc_fault;
    err_t          enc_err;
    logic          pc_ovf;

    mips_instr_pack u_pack (
        .op       (in_op),
        .rs       (in_rs),
        .rt       (in_rt),
        .rd       (in_rd),
        .imm      (in_imm),
        .target   (in_target),
        .pc       (pc),
        .word     (enc_word),
        .fault    (enc_fault),
        .err_code (enc_err)
    );

    // No wrap-around: a word index past the end of IMEM is refused before writing.
    assign pc_ovf = ({2'b00, pc[31:2]} >= 32'(MEM_DEPTH));

    // Session FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr_count <= '0;
            pc          <= '0;
            last_q      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (state == ST_DONE) state <= ST_IDLE;
                    if (start) begin
                        if (base_addr[1:0] != 2'b00) begin
                            state    <= ST_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_ALIGN;
                        end else begin
                            state       <= ST_ACCEPT;
                            pc          <= base_addr;
                            instr_count <= '0;
                            err         <= 1'b0;
                            err_code    <= ERR_NONE;
                            in_ready    <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (enc_fault || pc_ovf) begin
                            state    <= ST_ERR;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= enc_fault ? enc_err : ERR_MEM_OVF;
                        end else begin
                            state     <= ST_WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= enc_word;
                            mem_addr  <= pc[ADDR_W+1:2];
                            last_q    <= in_last;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_we      <= 1'b0;
                        pc          <= pc + 32'd4;
                        instr_count <= instr_count + (ADDR_W+1)'(1);
                        if (last_q) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ST_ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed cases plus randomized
// sessions checked against an arithmetic reference model of the encoding rules.
module tb_mips_instr_encoder;
    import mips_instr_encoder_pkg::*;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    mnem_t             in_op = MN_ADD;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_rd = '0;
    logic [15:0]       in_imm = '0;
    logic [31:0]       in_target = '0;
    logic              in_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    err_t              err_code;
    logic [ADDR_W:0]   instr_count;

    mips_instr_encoder #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc = '0;
    int          m_count = 0;
    logic [31:0] seen_word = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: encoding computed with plain integer arithmetic from the ISA rules.
    function automatic void ref_encode(input int unsigned op, input int unsigned rs,
                                       input int unsigned rt, input int unsigned rd,
                                       input int unsigned imm, input logic [31:0] tgt,
                                       input logic [31:0] pc, output logic [31:0] word,
                                       output logic [31:0] code);
        int unsigned w;
        logic [31:0] pc4;
        int diff;
        int off;
        w    = 0;
        code = ERR_NONE;
        pc4  = pc + 32'd4;
        case (op)
            0: w = rs * (2**21) + rt * (2**16) + rd * (2**11) + 32;
            1: w = rs * (2**21) + rt * (2**16) + rd * (2**11) + 34;
            2: w = rs * (2**21) + rt * (2**16) + rd * (2**11) + 36;
            3: w = rs * (2**21) + rt * (2**16) + rd * (2**11) + 37;
            4: w = rs * (2**21) + rt * (2**16) + rd * (2**11) + 42;
            5: w = 35 * (2**26) + rs * (2**21) + rt * (2**16) + imm;
            6: w = 43 * (2**26) + rs * (2**21) + rt * (2**16) + imm;
            8: w = 8 * (2**26) + rs * (2**21) + rt * (2**16) + imm;
            7: begin
                diff = int'(tgt - pc4);
                if (tgt % 4 != 0) code = ERR_BR_RANGE;
                else begin
                    off = diff / 4;
                    if (off < -32768 || off > 32767) code = ERR_BR_RANGE;
                    else w = 4 * (2**26) + rs * (2**21) + rt * (2**16) + (32'(off) & 32'hFFFF);
                end
            end
            9: begin
                if (tgt % 4 != 0 || tgt / (2**28) != pc4 / (2**28)) code = ERR_J_REGION;
                else w = 2 * (2**26) + (tgt % (2**28)) / 4;
            end
            default: code = ERR_BAD_OP;
        endcase
        if (code == ERR_NONE && pc / 4 >= MEM_DEPTH) code = ERR_MEM_OVF;
        word = w;
    endfunction

    task automatic start_session(input logic [31:0] base, output bit ok);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        if (base % 4 != 0) begin
            check_eq("align_err", err, 1);
            check_eq("align_code", err_code, ERR_ALIGN);
            check_eq("align_busy", busy, 0);
            ok = 0;
        end else begin
            check_eq("start_busy", busy, 1);
            check_eq("start_rdy", in_ready, 1);
            check_eq("start_err", err, 0);
            check_eq("start_cnt", instr_count, 0);
            m_pc    = base;
            m_count = 0;
            ok      = 1;
        end
    endtask

    task automatic send_instr(input int unsigned op, input int unsigned rs, input int unsigned rt,
                              input int unsigned rd, input int unsigned imm, input logic [31:0] tgt,
                              input bit last, input int unsigned stall, output bit faulted);
        logic [31:0] exp_word;
        logic [31:0] exp_code;
        ref_encode(op, rs, rt, rd, imm, tgt, m_pc, exp_word, exp_code);
        check_eq("acc_rdy", in_ready, 1);
        in_valid  = 1'b1;
        in_op     = mnem_t'(4'(op));
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
        in_target = tgt;
        in_last   = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (exp_code != ERR_NONE) begin
            faulted = 1;
            check_eq("flt_err", err, 1);
            check_eq("flt_code", err_code, exp_code);
            check_eq("flt_we", mem_we, 0);
            check_eq("flt_busy", busy, 0);
            @(posedge clk); #1;
            check_eq("flt_sticky", err, 1);
            check_eq("flt_we2", mem_we, 0);
            check_eq("flt_cnt", instr_count, 32'(m_count));
            return;
        end
        faulted   = 0;
        seen_word = mem_wdata;
        check_eq("wr_we", mem_we, 1);
        check_eq("wr_addr", mem_addr, (m_pc / 4) % MEM_DEPTH);
        check_eq("wr_data", mem_wdata, exp_word);
        check_eq("wr_rdy", in_ready, 0);
        for (int unsigned k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check_eq("hold_we", mem_we, 1);
            check_eq("hold_data", mem_wdata, exp_word);
            check_eq("hold_rdy", in_ready, 0);
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 1;
        check_eq("post_we", mem_we, 0);
        check_eq("post_cnt", instr_count, 32'(m_count));
        if (last) begin
            check_eq("done_pulse", done, 1);
            check_eq("done_busy", busy, 0);
            @(posedge clk); #1;
            check_eq("done_clear", done, 0);
            check_eq("idle_busy", busy, 0);
        end else begin
            check_eq("next_rdy", in_ready, 1);
            check_eq("next_done", done, 0);
        end
    endtask

    initial begin
        bit ok;
        bit f;
        #1;
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_rdy", in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_code", err_code, ERR_NONE);
        check_eq("rst_cnt", instr_count, 0);
        check_eq("rst_addr", mem_addr, 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD
        start_session(32'h0, ok);
        send_instr(0, 1, 2, 3, 0, 0, 1, 0, f);
        check_eq("spec_add", seen_word, 32'h00221820);

        // LW / SW / ADDI with a stalled second write
        start_session(32'h0, ok);
        send_instr(5, 0, 8, 0, 4, 0, 0, 0, f);
        check_eq("spec_lw", seen_word, 32'h8C080004);
        send_instr(6, 0, 8, 0, 8, 0, 0, 3, f);
        check_eq("spec_sw", seen_word, 32'hAC080008);
        send_instr(8, 8, 9, 0, 16'hFFFF, 0, 1, 0, f);
        check_eq("spec_addi", seen_word, 32'h2109FFFF);

        // BEQ back-branch then out-of-range branch
        start_session(32'h10, ok);
        send_instr(7, 1, 2, 0, 0, 32'h4, 0, 0, f);
        check_eq("spec_beq", seen_word, 32'h1022FFFC);
        send_instr(7, 1, 2, 0, 0, 32'h14 + 32'h20000 + 32'h4, 1, 0, f);
        check_eq("beq_range_fault", 32'(f), 1);

        // J in-region then cross-region
        start_session(32'h0, ok);
        send_instr(9, 0, 0, 0, 0, 32'h0040_0000, 0, 0, f);
        check_eq("spec_j", seen_word, 32'h08100000);
        send_instr(9, 0, 0, 0, 0, 32'h1000_0000, 1, 0, f);
        check_eq("j_region_fault", 32'(f), 1);
        start_session(32'h0, ok);
        send_instr(1, 4, 5, 6, 0, 0, 1, 1, f);

        // Last IMEM word then overflow; misaligned base
        start_session(32'h3FC, ok);
        send_instr(3, 7, 7, 7, 0, 0, 0, 0, f);
        check_eq("last_word_addr_ok", 32'(f), 0);
        send_instr(3, 7, 7, 7, 0, 0, 1, 0, f);
        check_eq("ovf_fault", 32'(f), 1);
        start_session(32'h2, ok);

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            logic [31:0] base;
            int unsigned n;
            base = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(250, 255) * 4)
                                               : 32'($urandom_range(0, 200) * 4);
            if ($urandom_range(0, 9) == 0) base = base | 32'h2;
            start_session(base, ok);
            if (!ok) continue;
            n = $urandom_range(1, 6);
            for (int unsigned i = 0; i < n; i++) begin
                int unsigned op;
                int unsigned r;
                logic [31:0] tgt;
                int k;
                r  = $urandom_range(0, 11);
                op = (r < 10) ? r : $urandom_range(10, 15);
                tgt = $urandom;
                if (op == 7) begin
                    k   = int'($urandom_range(0, 80000)) - 40000;
                    tgt = m_pc + 32'd4 + 32'(k * 4);
                    if ($urandom_range(0, 7) == 0) tgt = tgt + 32'd1;
                end else if (op == 9 && $urandom_range(0, 3) != 0) begin
                    tgt = {4'h0, tgt[27:2], 2'b00};
                end
                send_instr(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                           $urandom_range(0, 65535), tgt, (i == n - 1), $urandom_range(0, 2), f);
                if (f) break;
            end
        end

        // Reset in the middle of a stalled write
        start_session(32'h40, ok);
        in_valid = 1'b1;
        in_op    = MN_OR;
        in_last  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("pre_rst_we", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_we", mem_we, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_rdy", in_ready, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_err", err, 0);
        check_eq("arst_code", err_code, ERR_NONE);
        check_eq("arst_addr", mem_addr, 0);
        check_eq("arst_data", mem_wdata, 0);
        check_eq("arst_cnt", instr_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_we", mem_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
